morse_symbol_timer: RTL and testbench

//  Parametrised Morse key timing classifier. Measures key-press and key-gap durations and emits
//  one-cycle symbol strobes: dot, dash, invalid press, letter gap, word gap and send.

---
 rtl/morse_symbol_timer.sv | 247 ++++++++++++++++++++++++
 tb/tb_morse_symbol_timer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_symbol_timer.sv
// morse_symbol_timer
// Classifies Morse key activity into one-cycle symbol strobes: dot, dash,
// invalid press, letter gap, word gap and send. The raw key and send inputs
// are synchronised, and the key is debounced, before any timing is measured.
// Optional feature macro: MORSE_SYM_LEN_EN adds the sym_len output that
// reports the measured duration of each emitted symbol.

module morse_symbol_timer #(
  parameter int CNT_W      = 16,
  parameter int DEBOUNCE   = 3,
  parameter int DOT_MAX    = 5,
  parameter int DASH_MIN   = 15,
  parameter int LETTER_GAP = 30,
  parameter int WORD_GAP   = 70
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             button,
  input  logic             send,
  output logic             sym_valid,
  output logic [2:0]       sym_code,
  output logic             key_down
`ifdef MORSE_SYM_LEN_EN
  ,
  output logic [CNT_W-1:0] sym_len
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic [2:0] CODE_NONE    = 3'b000;
  localparam logic [2:0] CODE_DOT     = 3'b001;
  localparam logic [2:0] CODE_DASH    = 3'b010;
  localparam logic [2:0] CODE_SEND    = 3'b011;
  localparam logic [2:0] CODE_LETTER  = 3'b100;
  localparam logic [2:0] CODE_WORD    = 3'b101;
  localparam logic [2:0] CODE_INVALID = 3'b110;

  localparam int              DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1'b1);

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DOT_MAX_C    = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] DASH_MIN_C   = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] LETTER_GAP_C = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WORD_GAP_C   = CNT_W'(WORD_GAP);

  logic             btn_meta_r, btn_sync_r;
  logic             snd_meta_r, snd_sync_r, snd_prev_r;
  logic             send_edge_s;
  logic             key_down_r;
  logic [DB_W-1:0]  db_cnt_r, db_cnt_next_s;
  logic             key_toggle_s, key_rise_s, key_fall_s;
  state_e           state_r, state_next_s;
  logic [CNT_W-1:0] press_cnt_r, press_next_s, press_inc_s;
  logic [CNT_W-1:0] gap_cnt_r, gap_next_s, gap_inc_s;
  logic             send_pend_r, send_pend_next_s;
  logic             sym_valid_r, sym_valid_next_s;
  logic [2:0]       sym_code_r, sym_code_next_s;

  // Two-flop synchronisers for both asynchronous inputs, plus send history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
      snd_meta_r <= 1'b0;
      snd_sync_r <= 1'b0;
      snd_prev_r <= 1'b0;
    end else begin
      btn_meta_r <= button;
      btn_sync_r <= btn_meta_r;
      snd_meta_r <= send;
      snd_sync_r <= snd_meta_r;
      snd_prev_r <= snd_sync_r;
    end
  end

  assign send_edge_s = snd_sync_r & ~snd_prev_r;

  // Debounce: the accepted level flips on the DEBOUNCE-th consecutive disagreeing cycle.
  always_comb begin
    key_toggle_s  = 1'b0;
    db_cnt_next_s = DB_ZERO;
    if (btn_sync_r != key_down_r) begin
      if (db_cnt_r == DB_LAST) begin
        key_toggle_s  = 1'b1;
        db_cnt_next_s = DB_ZERO;
      end else begin
        db_cnt_next_s = db_cnt_r + DB_ONE;
      end
    end else begin
      db_cnt_next_s = DB_ZERO;
    end
  end

  assign key_rise_s = key_toggle_s & ~key_down_r;
  assign key_fall_s = key_toggle_s &  key_down_r;

  // Accepted key level and its disagreement counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_down_r <= 1'b0;
      db_cnt_r   <= DB_ZERO;
    end else begin
      key_down_r <= key_down_r ^ key_toggle_s;
      db_cnt_r   <= db_cnt_next_s;
    end
  end

  assign press_inc_s = (press_cnt_r == CNT_MAX) ? press_cnt_r : press_cnt_r + CNT_ONE;
  assign gap_inc_s   = (gap_cnt_r   == CNT_MAX) ? gap_cnt_r   : gap_cnt_r   + CNT_ONE;

  // Next state, counters and symbol; the press classification always wins the strobe slot.
  always_comb begin
    state_next_s     = state_r;
    press_next_s     = press_cnt_r;
    gap_next_s       = gap_cnt_r;
    send_pend_next_s = send_pend_r;
    sym_valid_next_s = 1'b0;
    sym_code_next_s  = CODE_NONE;
    case (state_r)
      ST_IDLE: begin
        if (key_rise_s) begin
          state_next_s = ST_PRESS;
          press_next_s = CNT_ONE;
          gap_next_s   = CNT_ZERO;
        end else begin
          gap_next_s   = CNT_ZERO;
        end
      end
      ST_PRESS: begin
        if (key_fall_s) begin
          sym_valid_next_s = 1'b1;
          if (press_cnt_r <= DOT_MAX_C) begin
            sym_code_next_s = CODE_DOT;
          end else if (press_cnt_r >= DASH_MIN_C) begin
            sym_code_next_s = CODE_DASH;
          end else begin
            sym_code_next_s = CODE_INVALID;
          end
          state_next_s = ST_GAP;
          gap_next_s   = CNT_ONE;
        end else begin
          press_next_s = press_inc_s;
        end
      end
      ST_GAP: begin
        if (key_rise_s) begin
          // A new press ends the gap silently if no threshold has been reached yet.
          state_next_s = ST_PRESS;
          press_next_s = CNT_ONE;
          gap_next_s   = CNT_ZERO;
        end else if (gap_inc_s == WORD_GAP_C) begin
          sym_valid_next_s = 1'b1;
          sym_code_next_s  = CODE_WORD;
          state_next_s     = ST_IDLE;
          gap_next_s       = CNT_ZERO;
        end else if (gap_inc_s == LETTER_GAP_C) begin
          sym_valid_next_s = 1'b1;
          sym_code_next_s  = CODE_LETTER;
          gap_next_s       = gap_inc_s;
        end else begin
          gap_next_s       = gap_inc_s;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        press_next_s = CNT_ZERO;
        gap_next_s   = CNT_ZERO;
      end
    endcase
    // A pending send takes the first free strobe slot and cancels any gap in progress.
    if (send_pend_r && !sym_valid_next_s) begin
      sym_valid_next_s = 1'b1;
      sym_code_next_s  = CODE_SEND;
      send_pend_next_s = 1'b0;
      if (state_next_s == ST_GAP) begin
        state_next_s = ST_IDLE;
        gap_next_s   = CNT_ZERO;
      end else begin
        state_next_s = state_next_s;
      end
    end else if (send_edge_s) begin
      send_pend_next_s = 1'b1;
    end else begin
      send_pend_next_s = send_pend_r;
    end
  end

  // Registered FSM state, counters, pending send and symbol outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      press_cnt_r <= CNT_ZERO;
      gap_cnt_r   <= CNT_ZERO;
      send_pend_r <= 1'b0;
      sym_valid_r <= 1'b0;
      sym_code_r  <= CODE_NONE;
    end else begin
      state_r     <= state_next_s;
      press_cnt_r <= press_next_s;
      gap_cnt_r   <= gap_next_s;
      send_pend_r <= send_pend_next_s;
      sym_valid_r <= sym_valid_next_s;
      sym_code_r  <= sym_code_next_s;
    end
  end

  assign sym_valid = sym_valid_r;
  assign sym_code  = sym_code_r;
  assign key_down  = key_down_r;

`ifdef MORSE_SYM_LEN_EN
  logic [CNT_W-1:0] sym_len_r, sym_len_next_s;

  // Duration reported with each strobe: press length, gap length, or zero for send.
  always_comb begin
    sym_len_next_s = sym_len_r;
    case (sym_code_next_s)
      CODE_DOT, CODE_DASH, CODE_INVALID: sym_len_next_s = press_cnt_r;
      CODE_LETTER, CODE_WORD:            sym_len_next_s = gap_inc_s;
      CODE_SEND:                         sym_len_next_s = CNT_ZERO;
      default:                           sym_len_next_s = sym_len_r;
    endcase
  end

  // Length register holds its value between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_len_r <= CNT_ZERO;
    end else begin
      sym_len_r <= sym_len_next_s;
    end
  end

  assign sym_len = sym_len_r;
`endif

endmodule

// File: tb/tb_morse_symbol_timer.sv
// Self-checking bench for morse_symbol_timer (default parameters).
// A timestamp-based model predicts the strobes from the sampled inputs;
// directed scenarios also pin the model with hand-computed event lists.

module tb_morse_symbol_timer;

  localparam int CNT_W      = 16;
  localparam int DEBOUNCE   = 3;
  localparam int DOT_MAX    = 5;
  localparam int DASH_MIN   = 15;
  localparam int LETTER_GAP = 30;
  localparam int WORD_GAP   = 70;
  localparam int MAXC       = 4096;

  localparam int C_DOT = 1, C_DASH = 2, C_SEND = 3, C_LETTER = 4, C_WORD = 5, C_INV = 6;

  logic clk = 1'b0;
  logic rst_n, button, send;
  logic sym_valid;
  logic [2:0] sym_code;
  logic key_down;
`ifdef MORSE_SYM_LEN_EN
  logic [CNT_W-1:0] sym_len;
`endif

  morse_symbol_timer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button    (button),
    .send      (send),
    .sym_valid (sym_valid),
    .sym_code  (sym_code),
    .key_down  (key_down)
`ifdef MORSE_SYM_LEN_EN
    ,
    .sym_len   (sym_len)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int cyc;
    int code;
    int len;
  } ev_t;

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  last_rst = 0;
  bit  sb [MAXC];
  bit  ss [MAXC];
  bit  sr [MAXC];
  ev_t evlog [$];

  // model state
  bit  mkey = 1'b0, mpend = 1'b0, gap_open = 1'b0, flip, ev, sedge;
  int  press_start = 0, gap_start = 0, mlen = 0, code = 0, len = 0, g = 0;
  logic [2:0] ecode;

  // Record what the DUT samples on each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (cyc < MAXC) begin
        sb[cyc] = button;
        ss[cyc] = send;
        sr[cyc] = rst_n;
      end
    end
  end

  function automatic bit eff_b(int y);
    if (y < 1 || y <= last_rst || y >= MAXC) return 1'b0;
    return sb[y];
  endfunction

  function automatic bit eff_s(int y);
    if (y < 1 || y <= last_rst || y >= MAXC) return 1'b0;
    return ss[y];
  endfunction

  function automatic ev_t ev_at(int i);
    ev_t e;
    e.cyc = -1; e.code = -1; e.len = -1;
    if (i < evlog.size()) e = evlog[i];
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: predict each cycle from spec-level rules, then compare the DUT.
  initial begin
    forever begin
      @(negedge clk);
      ev = 1'b0; code = 0; len = 0;
      if (!rst_n || !sr[cyc]) begin
        last_rst = cyc; mkey = 1'b0; mpend = 1'b0; gap_open = 1'b0; mlen = 0;
      end else begin
        flip = 1'b1;
        for (int j = 0; j < DEBOUNCE; j++) if (eff_b(cyc - 2 - j) == mkey) flip = 1'b0;
        if (flip && !mkey) begin
          mkey = 1'b1; press_start = cyc; gap_open = 1'b0;
        end else if (flip && mkey) begin
          mkey = 1'b0; len = cyc - press_start; ev = 1'b1;
          code = (len <= DOT_MAX) ? C_DOT : ((len >= DASH_MIN) ? C_DASH : C_INV);
          gap_start = cyc; gap_open = 1'b1;
        end else if (gap_open) begin
          g = cyc - gap_start + 1;
          if (g == WORD_GAP) begin
            ev = 1'b1; code = C_WORD; len = g; gap_open = 1'b0;
          end else if (g == LETTER_GAP) begin
            ev = 1'b1; code = C_LETTER; len = g;
          end
        end
        sedge = eff_s(cyc - 2) && !eff_s(cyc - 3);
        if (mpend && !ev) begin
          ev = 1'b1; code = C_SEND; len = 0; mpend = 1'b0; gap_open = 1'b0;
        end else if (sedge) begin
          mpend = 1'b1;
        end
        if (ev) begin
          mlen = len;
          evlog.push_back('{cyc: cyc, code: code, len: len});
        end
      end
      ecode = ev ? 3'(code) : 3'b000;
      tests = tests + 1;
      if (sym_valid !== ev || sym_code !== ecode || key_down !== mkey
`ifdef MORSE_SYM_LEN_EN
          || sym_len !== CNT_W'(mlen)
`endif
         ) begin
        fails = fails + 1;
        $display("FAIL cycle_%0d: valid/code/key got %0b/%0d/%0b expected %0b/%0d/%0b",
                 cyc, sym_valid, sym_code, key_down, ev, ecode, mkey);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(int n, int rest);
    button = 1'b1; step(n);
    button = 1'b0; step(rest);
  endtask

  int b;
  ev_t e0, e1, e2;

  initial begin
    rst_n = 1'b0; button = 1'b0; send = 1'b0;
    step(3);
    chk("reset_valid", int'(sym_valid), 0);
    chk("reset_code", int'(sym_code), 0);
    chk("reset_key", int'(key_down), 0);
    rst_n = 1'b1;
    step(5);

    // dot, then letter gap 29 cycles later, word gap 40 after that
    b = evlog.size(); press(3, 80);
    e0 = ev_at(b); e1 = ev_at(b + 1); e2 = ev_at(b + 2);
    chk("s1_count", evlog.size() - b, 3);
    chk("s1_dot_code", e0.code, C_DOT);      chk("s1_dot_len", e0.len, 3);
    chk("s1_letter_code", e1.code, C_LETTER); chk("s1_letter_len", e1.len, 30);
    chk("s1_letter_dist", e1.cyc - e0.cyc, 29);
    chk("s1_word_code", e2.code, C_WORD);    chk("s1_word_len", e2.len, 70);
    chk("s1_word_dist", e2.cyc - e1.cyc, 40);

    // dash and invalid press
    b = evlog.size(); press(20, 80);
    e0 = ev_at(b);
    chk("s2_dash_code", e0.code, C_DASH); chk("s2_dash_len", e0.len, 20);
    b = evlog.size(); press(10, 80);
    e0 = ev_at(b);
    chk("s3_inv_code", e0.code, C_INV); chk("s3_inv_len", e0.len, 10);

    // short glitch is ignored, chatter inside a held press is absorbed
    b = evlog.size(); press(2, 10);
    chk("s4_glitch_count", evlog.size() - b, 0);
    b = evlog.size();
    button = 1'b1; step(8);
    button = 1'b0; step(1);
    button = 1'b1; step(1);
    button = 1'b0; step(1);
    button = 1'b1; step(9);
    button = 1'b0; step(80);
    e0 = ev_at(b);
    chk("s4_chatter_code", e0.code, C_DASH); chk("s4_chatter_len", e0.len, 20);

    // send request becomes pending on the dot strobe cycle
    b = evlog.size();
    button = 1'b1; step(3);
    button = 1'b0; step(2);
    send = 1'b1; step(4);
    send = 1'b0; step(80);
    e0 = ev_at(b); e1 = ev_at(b + 1);
    chk("s5_count", evlog.size() - b, 2);
    chk("s5_dot_code", e0.code, C_DOT);
    chk("s5_send_code", e1.code, C_SEND); chk("s5_send_len", e1.len, 0);
    chk("s5_send_dist", e1.cyc - e0.cyc, 1);

    // reset in the middle of a press aborts it
    b = evlog.size();
    button = 1'b1; step(15);
    rst_n = 1'b0; button = 1'b0; step(1);
    rst_n = 1'b1; step(20);
    chk("s6_abort_count", evlog.size() - b, 0);
    chk("s6_abort_key", int'(key_down), 0);
    b = evlog.size(); press(4, 80);
    e0 = ev_at(b);
    chk("s6_dot_code", e0.code, C_DOT); chk("s6_dot_len", e0.len, 4);

    // short gap between two presses produces no gap symbol
    b = evlog.size();
    button = 1'b1; step(5);
    button = 1'b0; step(10);
    button = 1'b1; step(16);
    button = 1'b0; step(80);
    e0 = ev_at(b); e1 = ev_at(b + 1);
    chk("s7_count", evlog.size() - b, 4);
    chk("s7_dot_code", e0.code, C_DOT);   chk("s7_dot_len", e0.len, 5);
    chk("s7_dash_code", e1.code, C_DASH); chk("s7_dash_len", e1.len, 16);
    chk("s7_dash_dist", e1.cyc - e0.cyc, 26);

    // send while idle
    b = evlog.size();
    send = 1'b1; step(3);
    send = 1'b0; step(10);
    e0 = ev_at(b);
    chk("s8_count", evlog.size() - b, 1);
    chk("s8_send_code", e0.code, C_SEND);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
